// File: rtl/move_input.sv
// Conditions the raw move button for the scroll stage: two-flop synchroniser,
// debounce counter, and an arm flag that keeps movement off until a release.
module move_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic game_rst,
    input  logic btn_raw,
    input  logic halt,
    output logic move_btn,
    output logic press,
    output logic db_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dbState_q;
    logic             dbState_d;
    logic             dbPrev_q;
    logic             armed_q;
    logic             armed_d;
    logic             press_q;
    logic             press_d;

    // Any sample that agrees with the debounced level throws the count away.
    always_comb begin
        cnt_d     = cnt_q;
        dbState_d = dbState_q;
        if (sync2_q == dbState_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            dbState_d = sync2_q;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Clearing wins over setting, so a button held through a restart stays disarmed.
    always_comb begin
        armed_d = armed_q;
        if (game_rst || halt) begin
            armed_d = 1'b0;
        end else if (!dbState_q) begin
            armed_d = 1'b1;
        end
    end

    assign press_d = ~dbPrev_q & dbState_q & armed_q & ~halt & ~game_rst;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            dbState_q <= 1'b0;
            dbPrev_q  <= 1'b0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            dbState_q <= dbState_d;
            dbPrev_q  <= dbState_q;
            armed_q   <= armed_d;
            press_q   <= press_d;
        end
    end

    assign move_btn = dbState_q & armed_q & ~halt;
    assign press    = press_q;
    assign db_state = dbState_q;

endmodule

// File: tb/tb_move_input.sv
// Scoreboard bench for move_input with DEBOUNCE_CYCLES=4: stimulus pushes hand-computed
// {move_btn, press, db_state} expectations, a monitor pops and compares them.
module tb_move_input;

    logic clk;
    logic sys_rst;
    logic game_rst;
    logic btn_raw;
    logic halt;
    logic move_btn;
    logic press;
    logic db_state;

    typedef struct {
        logic  m;
        logic  p;
        logic  d;
        string tag;
    } exp_t;

    exp_t expQ[$];
    int   nVectors = 0;
    int   nMiss    = 0;
    event sampleEv;

    move_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .game_rst(game_rst),
        .btn_raw (btn_raw),
        .halt    (halt),
        .move_btn(move_btn),
        .press   (press),
        .db_state(db_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each entry is checked 1 time unit after the clock edge (or an immediate-check event).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sampleEv);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nVectors++;
                if ({move_btn, press, db_state} !== {e.m, e.p, e.d}) begin
                    nMiss++;
                    $display("[TB] FAIL %s: move/press/db got %b%b%b expected %b%b%b at %0t",
                             e.tag, move_btn, press, db_state, e.m, e.p, e.d, $time);
                end
            end
        end
    end

    task automatic pushExp(input logic m, input logic p, input logic d, input string tag);
        exp_t e;
        e.m = m;
        e.p = p;
        e.d = d;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    // One cycle: drive inputs at the falling edge, expect outputs after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic b, input logic h, input logic g,
                                 input logic m, input logic p, input logic d, input string tag);
        @(negedge clk);
        sys_rst  = rst;
        btn_raw  = b;
        halt     = h;
        game_rst = g;
        pushExp(m, p, d, tag);
    endtask

    // Immediate check of outputs without waiting for a clock edge.
    task automatic checkOutput(input logic m, input logic p, input logic d, input string tag);
        pushExp(m, p, d, tag);
        -> sampleEv;
        #2;
    endtask

    task automatic holdSeq(input int n, input logic b, input logic m, input logic p,
                           input logic d, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, b, 1'b0, 1'b0, m, p, d, tag);
    endtask

    // Press from a settled released state while armed: db/move rise on the 6th edge, press on the 7th.
    task automatic pressSeq(input string tag);
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, (i >= 6), (i == 7), (i >= 6), tag);
    endtask

    task automatic releaseSeq(input logic movedBefore, input string tag);
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, movedBefore & (i < 6), 1'b0, (i < 6), tag);
    endtask

    initial begin
        sys_rst  = 1'b1;
        game_rst = 1'b0;
        btn_raw  = 1'b0;
        halt     = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "reset");
        holdSeq(2, 1'b0, 0, 0, 0, "arm");

        // Basic press and release latency.
        pressSeq("t1 press");
        holdSeq(2, 1'b1, 1, 0, 1, "t1 hold");
        releaseSeq(1'b1, "t1 release");

        // Glitch pattern 3 high, 1 low, 3 high never reaches the debounce threshold.
        holdSeq(2, 1'b0, 0, 0, 0, "glitch idle");
        begin
            logic [6:0] pat;
            pat = 7'b1110111;
            for (int i = 6; i >= 0; i--) applyStimulus(1'b0, pat[i], 1'b0, 1'b0, 0, 0, 0, "glitch");
        end
        holdSeq(7, 1'b0, 0, 0, 0, "glitch after");

        // Halt while held: combinational drop, stays off until release and re-press.
        pressSeq("t3 press");
        holdSeq(2, 1'b1, 1, 0, 1, "t3 hold");
        @(negedge clk);
        #2;
        halt = 1'b1;
        checkOutput(0, 0, 1, "halt same cycle");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1, "halt held");
        holdSeq(5, 1'b1, 0, 0, 1, "after halt held");
        releaseSeq(1'b0, "t3 release");
        pressSeq("t3 repress");

        // Restart pulse while held disarms until release.
        holdSeq(2, 1'b1, 1, 0, 1, "t4 hold");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1, "game_rst pulse");
        holdSeq(4, 1'b1, 0, 0, 1, "after game_rst");
        releaseSeq(1'b0, "t4 release");
        pressSeq("t4 repress");

        // Restart in the same cycle the debounced level rises suppresses press.
        releaseSeq(1'b1, "t5 release");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "t5 count");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1, "t5 rise");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1, "t5 rst no press");
        holdSeq(3, 1'b1, 0, 0, 1, "t5 held");
        releaseSeq(1'b0, "t5 release2");
        pressSeq("t5 repress");

        // Async reset while db_state is high.
        holdSeq(2, 1'b1, 1, 0, 1, "t6 hold");
        @(negedge clk);
        #2;
        sys_rst = 1'b1;
        checkOutput(0, 0, 0, "async rst db high");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, "in reset");
        pressSeq("t6 after reset");

        // Async reset mid-count, then the count restarts from zero.
        releaseSeq(1'b1, "t7 release");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "t7 count");
        @(negedge clk);
        #2;
        sys_rst = 1'b1;
        checkOutput(0, 0, 0, "async rst mid-count");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, "in reset2");
        pressSeq("t7 after reset");
        holdSeq(2, 1'b1, 1, 0, 1, "t7 hold");

        // Bouncing edge then stable high: exactly one press.
        releaseSeq(1'b1, "t8 release");
        holdSeq(2, 1'b0, 0, 0, 0, "t8 idle");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, (i % 2 == 0), 1'b0, 1'b0, 0, 0, 0, "bounce");
        pressSeq("t8 stable");
        holdSeq(3, 1'b1, 1, 0, 1, "t8 single press");
        releaseSeq(1'b1, "t8 final release");

        @(negedge clk);
        @(negedge clk);
        if (expQ.size() != 0) begin
            nMiss++;
            $display("[TB] FAIL queue drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

    initial begin
        #100000;
        nMiss++;
        $display("[TB] FAIL watchdog: run did not complete, %0d entries pending, expected 0", expQ.size());
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule

// File: doc/move_input.md
# move_input

Conditions the raw player move button for the scroll stage. Synchronises the asynchronous pad input, debounces it, and produces the clean `move_btn` level that `scroll` samples to advance lane position. Also gates movement during `halt` and after a game restart: the player must release the button before movement is re-enabled. Sits between the top-level button pin and `scroll`.

## Interface
- `DEBOUNCE_CYCLES`, 250000, consecutive stable synchronised samples required to change debounced state (10 ms at 25 MHz); legal range 2..2^24-1.
- `CNT_W`, 24, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  in  1  system clock (25 MHz).
- `sys_rst`  in  1  asynchronous, active-high reset of all state.
- `game_rst`  in  1  synchronous game restart, active-high; disarms movement.
- `btn_raw`  in  1  raw button pad, asynchronous to `clk`, active-high.
- `halt`  in  1  game halted (collision / game over); forces movement off.
- `move_btn`  out  1  qualified move level to `scroll`.
- `press`  out  1  one-cycle pulse on each qualified press.
- `db_state`  out  1  debounced button level, unqualified.

## Operation
- Sync: two flops `s1 <= btn_raw; s2 <= s1`; only `s2` is used downstream.
- Debounce counter `cnt` (CNT_W bits) and registered `db_state`:
  - `s2 == db_state`: `cnt <= 0`.
  - `s2 != db_state` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != db_state` and `cnt == DEBOUNCE_CYCLES-1`: `db_state <= s2`, `cnt <= 0`.
  - A single disagreeing-then-agreeing sample restarts the count; no partial credit.
- Arm flag `armed` (register):
  - Cleared any cycle `game_rst` or `halt` is 1 (priority over set).
  - Set any cycle `db_state == 0`, `halt == 0`, `game_rst == 0`.
  - Holding the button through a restart or halt therefore keeps movement off until a debounced release.
- `move_btn = db_state & armed & ~halt` (combinational from registers plus `halt`; `halt` takes effect the same cycle).
- `press` registered: `press <= ~db_prev & db_state & armed & ~halt & ~game_rst`, where `db_prev` is `db_state` delayed one cycle.
- `game_rst` does not touch sync flops, `cnt`, or `db_state`; it affects only `armed` and `press`.

## Timing
- Reset (`sys_rst` high, async): `s1=s2=0`, `cnt=0`, `db_state=0`, `db_prev=0`, `armed=0`, `press=0`; hence `move_btn=0`. First cycle after reset release with `db_state=0`, `halt=0`, `game_rst=0` sets `armed`.
- Press latency: `btn_raw` rising before edge E0 (held steady) -> `s2=1` after E1 -> `db_state=1` after edge E1+DEBOUNCE_CYCLES -> `move_btn=1` in that same cycle if armed -> `press=1` for exactly the following cycle.
- Release latency identical: `db_state`/`move_btn` fall 2+DEBOUNCE_CYCLES edges after stable release.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no change on any output.
- `halt` rises while held: `move_btn` drops same cycle, `armed` clears next edge; `move_btn` stays 0 after `halt` falls until release is debounced and re-press is debounced.
- `game_rst` and debounced rise on same cycle: `press=0`, `armed` cleared; `move_btn` may be 1 for that one cycle only if `armed` was already set (`scroll` ignores it during `game_rst`).
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- `sys_rst` mid-count: all state cleared immediately, count restarts from 0.

## Test plan
Benches use `DEBOUNCE_CYCLES=4`.
- Reset then `btn_raw` 0->1 held -> `db_state`/`move_btn` high exactly 6 edges after first sampling edge; `press` high for one cycle at edge 7; release -> `move_btn` low 6 edges later.
- `btn_raw` pulses high 3 cycles, low 1, high 3 -> `db_state`, `move_btn`, `press` remain 0 throughout.
- Held button, `halt` asserted 10 cycles then cleared while still held -> `move_btn` 0 same cycle as `halt` and stays 0; release, re-press -> `move_btn` 1 after 6 edges, one `press`.
- Held button, `game_rst` pulsed 1 cycle -> `move_btn` 0 from next cycle while held; after debounced release and re-press, movement returns.
- `sys_rst` asserted asynchronously mid-count (`cnt=2`) and while `db_state=1` -> all outputs 0 immediately, `cnt=0`; after release with `btn_raw` high, `move_btn` rises 6 edges later (armed set on first cycle).
- Bouncing edge (0/1 toggling every cycle for 8 cycles, then stable 1) -> single `press`, `move_btn` rises 6 edges after bouncing ends.
